sid_voice_bank: RTL and testbench
=================================

SID_VOICE_BANK -- requirements
Module: sid_voice_bank

Interface
REQ-001 The block SHALL provide parameter VOICES, default 3, giving the number of time-multiplexed voices (range 2..8).
REQ-002 The block SHALL provide parameter ACC_W, default 24, giving the phase accumulator width (range 20..32).
REQ-003 The block SHALL provide parameter NOISE_TAP, default 19, giving the accumulator bit that clocks the noise LFSR.
REQ-004 The block SHALL provide parameter BASE_ADDR, default 0, giving the address of voice 0 register 0.
REQ-005 The block SHALL provide parameter STRIDE, default 7, giving the address spacing between voices.
REQ-006 Port clk, input, 1 bit: master clock; single clock domain.
REQ-007 Port iRstN, input, 1 bit: asynchronous active-low reset.
REQ-008 Port clkEn, input, 1 bit: sample tick (1 MHz), one clk wide.
REQ-009 Port iWE, input, 1 bit: register write strobe.
REQ-010 Port iAddr, input, 5 bits: register address.
REQ-011 Port iData, input, 8 bits: write data.
REQ-012 Port oVoice, output, VOICES*12 bits: packed voice outputs, voice k at bits [12k+11:12k].
REQ-013 Port oValid, output, 1 bit: one-clk pulse when oVoice is updated.
REQ-014 Port oOverrun, output, 1 bit: sticky flag set when clkEn arrives during a sweep.

Function
REQ-015 Per-voice registers SHALL be freq[15:0] (offsets 0/1 = lo/hi), pw[11:0] (offset 2 = lo, offset 3 = hi nibble from iData[3:0]), and control (offset 4: noise[7], pulse[6], saw[5], tri[4], test[3], ring[2], sync[1]).
REQ-016 Voice k registers SHALL decode at BASE_ADDR+STRIDE*k+offset; other addresses SHALL be ignored.
REQ-017 Writes SHALL take effect on the clk after iWE, independent of clkEn and sequencer state.
REQ-018 The sequencer SHALL have states IDLE and SWEEP; clkEn in IDLE SHALL snapshot every voice MSB, zero the slot counter and enter SWEEP.
REQ-019 In SWEEP, slot k SHALL process voice k on the k-th clk after entry; after slot VOICES-1 the sequencer SHALL return to IDLE.
REQ-020 The phase, LFSR, tap-lag and MSB-lag state SHALL be held in per-voice storage, read and written only in that voice's slot.
REQ-021 The sync/ring source of voice k SHALL be voice (k-1) mod VOICES, using the snapshot MSB.
REQ-022 Phase update priority SHALL be: test=1 gives phase 0; else sync=1 with a falling source MSB (lag=1, snapshot=0) gives phase 0; else phase plus zero-extended freq, wrapping modulo 2^ACC_W.
REQ-023 The LFSR (23 bits) SHALL shift {lfsr[21:0], lfsr[22]^lfsr[21]} when phase[NOISE_TAP] rises (new=1, lag=0); test=1 SHALL force it to 23'h7FFFF8.
REQ-024 Waveforms SHALL derive from the updated phase, with P = phase[ACC_W-1 -: 12]: saw = P; pulse = (P >= pw or test) ? 0 : 12'hFFF; tri = (phase[ACC_W-1] ^ (ring & srcMSB)) ? phase[ACC_W-2 -: 12] : ~phase[ACC_W-2 -: 12]; noise = {lfsr bits 20,18,14,11,9,5,2,0, 4'b0}.
REQ-025 The mix SHALL be the AND of the enabled waveforms, with disabled waveforms contributing 12'hFFF; the voice output SHALL be the inverted mix, so a voice with no waveform enabled outputs 0.
REQ-026 Slot results SHALL be staged internally; all oVoice lanes SHALL update together, with oValid=1 for one clk, on the clk after the last slot (latency VOICES+1 clks from clkEn).
REQ-027 clkEn during SWEEP SHALL be ignored (no restart, no lost slot) and SHALL set oOverrun, which stays set until reset.
REQ-028 A write to a voice in the same clk as its slot SHALL NOT affect that slot; the slot SHALL use the pre-write value.

Reset
REQ-029 iRstN=0 SHALL immediately force: state IDLE; all registers 0; every phase 0x555...5 (even bits set, ACC_W wide); every LFSR 23'h7FFFF8; all lag bits 0; oVoice 0; oValid 0; oOverrun 0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep with no oValid; the first clkEn after release SHALL start a clean sweep.

Verification
REQ-031 Defaults, voice0 freq=0x1000, saw only, 4 clkEn spaced 10 clks -> oVoice[11:0]=0xAA6 (phase 0x559555), oValid pulse 4 clks after each clkEn.
REQ-032 Voice0 pw=0x800, pulse only, phase top 0x7FF -> lane 0 = 0x000; at top 0x800 -> 0xFFF; test=1 -> 0xFFF.
REQ-033 Voice1 sync=1, voice0 MSB 1 -> 0 between ticks -> voice1 phase 0 at that sweep; with sync=0 -> voice1 continues.
REQ-034 Voice2 test=1 for 3 ticks -> phase held 0, LFSR 0x7FFFF8; clear -> phase advances from 0 by freq.
REQ-035 clkEn every 2 clks with VOICES=3 -> oOverrun=1, each sweep completes with one oValid, no lane corruption.
REQ-036 iRstN pulsed low during slot 1 -> all outputs 0 that cycle, phases 0x555555, no oValid until the next clkEn+4.

Source files
------------

// File: rtl/sid_voice_bank_if.sv
// sid_voice_bank_if
//   Bundles the host-facing signals of sid_voice_bank.
//   clkEn    : one-clk-wide sample tick
//   iWE      : register write strobe
//   iAddr    : 5-bit register address
//   iData    : 8-bit write data
//   oVoice   : packed 12-bit voice lanes, voice k at [12k+11:12k]
//   oValid   : one-clk pulse when oVoice updates
//   oOverrun : sticky flag, a tick arrived while a sweep was running
//   master = host side, slave = sid_voice_bank.
interface sid_voice_bank_if #(
  parameter int VOICES = 3
);
  logic                   clkEn;
  logic                   iWE;
  logic [4:0]             iAddr;
  logic [7:0]             iData;
  logic [VOICES*12-1:0]   oVoice;
  logic                   oValid;
  logic                   oOverrun;

  modport master (
    output clkEn, iWE, iAddr, iData,
    input  oVoice, oValid, oOverrun
  );

  modport slave (
    input  clkEn, iWE, iAddr, iData,
    output oVoice, oValid, oOverrun
  );
endinterface

// File: rtl/sid_voice_bank.sv
// sid_voice_bank
//   Time-multiplexed bank of SID-style oscillator voices. Each sample tick
//   starts a sweep that updates one voice per clk (phase accumulator, noise
//   LFSR, hard sync, ring modulation, waveform mix). All lanes are published
//   together one clk after the last slot.
//   Ports:
//     clk   : master clock
//     iRstN : asynchronous active-low reset
//     bus   : sid_voice_bank_if slave (clkEn, register write bus, outputs)
module sid_voice_bank #(
  parameter int VOICES    = 3,
  parameter int ACC_W     = 24,
  parameter int NOISE_TAP = 19,
  parameter int BASE_ADDR = 0,
  parameter int STRIDE    = 7
) (
  input  logic            clk,
  input  logic            iRstN,
  sid_voice_bank_if.slave bus
);

  localparam int                SLOT_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(VOICES - 1);
  localparam logic [22:0]       LFSR_SEED = 23'h7FFFF8;

  function automatic logic [ACC_W-1:0] evenBits();
    logic [ACC_W-1:0] r;
    for (int i = 0; i < ACC_W; i++) r[i] = (i % 2 == 0);
    return r;
  endfunction

  localparam logic [ACC_W-1:0] PHASE_SEED = evenBits();

  // AND of the enabled waveforms (disabled ones pass all-ones), then inverted
  // so that a voice with nothing enabled is silent (0).
  function automatic logic [11:0] mixVoice(
    input logic [7:1]  c,
    input logic [11:0] sawW,
    input logic [11:0] pulseW,
    input logic [11:0] triW,
    input logic [11:0] noiseW
  );
    logic [11:0] m;
    m = 12'hFFF;
    if (c[7]) m = m & noiseW;
    if (c[6]) m = m & pulseW;
    if (c[5]) m = m & sawW;
    if (c[4]) m = m & triW;
    return ~m;
  endfunction

  typedef enum logic {IDLE, SWEEP} seqState_t;

  seqState_t            state;
  logic [SLOT_W-1:0]    slot;

  logic [15:0]          freq   [VOICES];
  logic [11:0]          pw     [VOICES];
  logic [7:1]           ctrl   [VOICES];

  logic [ACC_W-1:0]     phase  [VOICES];
  logic [22:0]          lfsr   [VOICES];
  logic [VOICES-1:0]    tapLag;
  logic [VOICES-1:0]    srcLag;
  logic [VOICES-1:0]    snapMsb;

  logic [11:0]          laneP1 [VOICES];
  logic                 vldP1;
  logic [VOICES*12-1:0] voiceP2;
  logic                 vldP2;
  logic                 overrun;

  logic [SLOT_W-1:0]    srcIdx;
  logic                 srcMsb;
  logic                 srcFall;
  logic [7:1]           curCtrl;
  logic [22:0]          curLfsr;
  logic [ACC_W-1:0]     nextPhase;
  logic [22:0]          nextLfsr;
  logic [11:0]          topP;
  logic [11:0]          pulseW;
  logic [11:0]          triW;
  logic [11:0]          noiseW;
  logic [11:0]          slotOut;

  // Register file: writes land on the next clk regardless of sweep state.
  // A slot reads these combinationally, so a same-clk write is not seen.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      for (int k = 0; k < VOICES; k++) begin
        freq[k] <= '0;
        pw[k]   <= '0;
        ctrl[k] <= '0;
      end
    end else if (bus.iWE) begin
      for (int k = 0; k < VOICES; k++) begin
        if (int'(bus.iAddr) == BASE_ADDR + STRIDE * k + 0) freq[k][7:0]  <= bus.iData;
        if (int'(bus.iAddr) == BASE_ADDR + STRIDE * k + 1) freq[k][15:8] <= bus.iData;
        if (int'(bus.iAddr) == BASE_ADDR + STRIDE * k + 2) pw[k][7:0]    <= bus.iData;
        if (int'(bus.iAddr) == BASE_ADDR + STRIDE * k + 3) pw[k][11:8]   <= bus.iData[3:0];
        if (int'(bus.iAddr) == BASE_ADDR + STRIDE * k + 4) ctrl[k]       <= bus.iData[7:1];
      end
    end
  end

  // Slot datapath (p0): next state and output of the voice in the current slot.
  // Sync/ring look at the previous voice through the MSB snapshot taken at
  // sweep start, so slot order does not leak updated phases into later slots.
  always_comb begin
    srcIdx  = (slot == '0) ? LAST_SLOT : slot - 1'b1;
    srcMsb  = snapMsb[srcIdx];
    srcFall = srcLag[slot] & ~srcMsb;
    curCtrl = ctrl[slot];
    curLfsr = lfsr[slot];

    if (curCtrl[3])
      nextPhase = '0;
    else if (curCtrl[1] && srcFall)
      nextPhase = '0;
    else
      nextPhase = phase[slot] + ACC_W'(freq[slot]);

    if (curCtrl[3])
      nextLfsr = LFSR_SEED;
    else if (nextPhase[NOISE_TAP] && !tapLag[slot])
      nextLfsr = {curLfsr[21:0], curLfsr[22] ^ curLfsr[21]};
    else
      nextLfsr = curLfsr;

    topP   = nextPhase[ACC_W-1 -: 12];
    pulseW = ((topP >= pw[slot]) || curCtrl[3]) ? 12'h000 : 12'hFFF;
    triW   = (nextPhase[ACC_W-1] ^ (curCtrl[2] & srcMsb)) ? nextPhase[ACC_W-2 -: 12]
                                                         : ~nextPhase[ACC_W-2 -: 12];
    noiseW = {nextLfsr[20], nextLfsr[18], nextLfsr[14], nextLfsr[11],
              nextLfsr[9],  nextLfsr[5],  nextLfsr[2],  nextLfsr[0], 4'b0000};
    slotOut = mixVoice(curCtrl, topP, pulseW, triW, noiseW);
  end

  // Slot results staged (p1), then published to all lanes at once (p2).
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state   <= IDLE;
      slot    <= '0;
      tapLag  <= '0;
      srcLag  <= '0;
      snapMsb <= '0;
      vldP1   <= 1'b0;
      voiceP2 <= '0;
      vldP2   <= 1'b0;
      overrun <= 1'b0;
      for (int k = 0; k < VOICES; k++) begin
        phase[k]  <= PHASE_SEED;
        lfsr[k]   <= LFSR_SEED;
        laneP1[k] <= '0;
      end
    end else begin
      vldP1 <= 1'b0;
      vldP2 <= vldP1;
      if (vldP1) begin
        for (int k = 0; k < VOICES; k++) voiceP2[12*k +: 12] <= laneP1[k];
      end

      case (state)
        IDLE: begin
          if (bus.clkEn) begin
            for (int k = 0; k < VOICES; k++) snapMsb[k] <= phase[k][ACC_W-1];
            slot  <= '0;
            state <= SWEEP;
          end
        end
        SWEEP: begin
          if (bus.clkEn) overrun <= 1'b1;
          phase[slot]  <= nextPhase;
          lfsr[slot]   <= nextLfsr;
          tapLag[slot] <= nextPhase[NOISE_TAP];
          srcLag[slot] <= srcMsb;
          laneP1[slot] <= slotOut;
          if (slot == LAST_SLOT) begin
            state <= IDLE;
            vldP1 <= 1'b1;
          end else begin
            slot <= slot + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oVoice   = voiceP2;
  assign bus.oValid   = vldP2;
  assign bus.oOverrun = overrun;

endmodule

// File: tb/tb_sid_voice_bank.sv
// tb_sid_voice_bank
//   Randomized bench for sid_voice_bank with a behavioural voice model that
//   computes a whole sweep per accepted tick using plain integer arithmetic.
module tb_sid_voice_bank;

  localparam int V  = 3;
  localparam int AW = 24;
  localparam int NT = 19;
  localparam int BA = 0;
  localparam int ST = 7;

  logic clk;
  logic iRstN;
  int   nVec;
  int   nErr;

  sid_voice_bank_if #(.VOICES(V)) bus ();

  sid_voice_bank #(
    .VOICES(V), .ACC_W(AW), .NOISE_TAP(NT), .BASE_ADDR(BA), .STRIDE(ST)
  ) dut (
    .clk   (clk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  longint         mPhase  [V];
  int             mLfsr   [V];
  bit             mTapLag [V];
  bit             mSrcLag [V];
  int             mFreq   [V];
  int             mPw     [V];
  int             mCtrl   [V];
  logic [V*12-1:0] expLanes;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int bitOf(input longint x, input int b);
    return int'((x >> b) & 64'd1);
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < V; k++) begin
      mPhase[k] = 0;
      for (int b = 0; b < AW; b += 2) mPhase[k] = mPhase[k] | (longint'(1) << b);
      mLfsr[k]   = 'h7FFFF8;
      mTapLag[k] = 0;
      mSrcLag[k] = 0;
      mFreq[k]   = 0;
      mPw[k]     = 0;
      mCtrl[k]   = 0;
    end
  endfunction

  function automatic void modelWrite(input int addr, input int data);
    int off;
    for (int k = 0; k < V; k++) begin
      off = addr - (BA + ST * k);
      case (off)
        0: mFreq[k] = (mFreq[k] & 'hFF00) | data;
        1: mFreq[k] = (mFreq[k] & 'h00FF) | (data << 8);
        2: mPw[k]   = (mPw[k] & 'hF00) | data;
        3: mPw[k]   = (mPw[k] & 'h0FF) | ((data & 'hF) << 8);
        4: mCtrl[k] = data & 'hFE;
        default: ;
      endcase
    end
  endfunction

  function automatic void modelSweep();
    bit snap [V];
    int src, test, sync, ring, tapNow, top, saw, pulse, tw, noise, mix, msb;
    int taps [8];
    taps = '{20, 18, 14, 11, 9, 5, 2, 0};
    for (int k = 0; k < V; k++) snap[k] = bitOf(mPhase[k], AW - 1) != 0;
    for (int k = 0; k < V; k++) begin
      src  = (k + V - 1) % V;
      test = (mCtrl[k] >> 3) & 1;
      ring = (mCtrl[k] >> 2) & 1;
      sync = (mCtrl[k] >> 1) & 1;
      if (test != 0) mPhase[k] = 0;
      else if (sync != 0 && mSrcLag[k] && !snap[src]) mPhase[k] = 0;
      else mPhase[k] = (mPhase[k] + longint'(mFreq[k])) % (longint'(1) << AW);
      mSrcLag[k] = snap[src];
      tapNow = bitOf(mPhase[k], NT);
      if (test != 0) mLfsr[k] = 'h7FFFF8;
      else if (tapNow != 0 && !mTapLag[k])
        mLfsr[k] = ((mLfsr[k] << 1) & 'h7FFFFF) | (((mLfsr[k] >> 22) ^ (mLfsr[k] >> 21)) & 1);
      mTapLag[k] = tapNow != 0;
      top   = int'(mPhase[k] >> (AW - 12)) & 'hFFF;
      saw   = top;
      pulse = (top >= mPw[k] || test != 0) ? 0 : 'hFFF;
      msb   = bitOf(mPhase[k], AW - 1);
      tw    = int'(mPhase[k] >> (AW - 13)) & 'hFFF;
      if ((msb ^ (ring & int'(snap[src]))) == 0) tw = 'hFFF - tw;
      noise = 0;
      for (int i = 0; i < 8; i++) noise = (noise << 1) | ((mLfsr[k] >> taps[i]) & 1);
      noise = noise << 4;
      mix = 'hFFF;
      if (((mCtrl[k] >> 7) & 1) != 0) mix = mix & noise;
      if (((mCtrl[k] >> 6) & 1) != 0) mix = mix & pulse;
      if (((mCtrl[k] >> 5) & 1) != 0) mix = mix & saw;
      if (((mCtrl[k] >> 4) & 1) != 0) mix = mix & tw;
      expLanes[12*k +: 12] = 12'('hFFF ^ mix);
    end
  endfunction

  task automatic writeReg(input int addr, input int data);
    @(negedge clk);
    bus.iWE   = 1'b1;
    bus.iAddr = 5'(addr);
    bus.iData = 8'(data);
    @(negedge clk);
    bus.iWE   = 1'b0;
    modelWrite(addr, data);
  endtask

  // One tick; optionally writes voice 0 in the very clk of its slot.
  task automatic doTick(input bit slotWr, input int wOff, input int wData);
    int lat;
    modelSweep();
    @(negedge clk);
    bus.clkEn = 1'b1;
    @(negedge clk);
    bus.clkEn = 1'b0;
    lat = 0;
    if (slotWr) begin
      bus.iWE   = 1'b1;
      bus.iAddr = 5'(BA + wOff);
      bus.iData = 8'(wData);
      @(negedge clk);
      bus.iWE   = 1'b0;
      lat = 1;
      modelWrite(BA + wOff, wData);
    end
    while (!bus.oValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkVal("validLatency", 64'(lat), 64'(V + 1));
    checkVal("lanes", 64'(bus.oVoice), 64'(expLanes));
    @(negedge clk);
    checkVal("validPulse", 64'(bus.oValid), 64'd0);
  endtask

  task automatic randomPhase(input int iters);
    int nw, v, off, d, a;
    for (int it = 0; it < iters; it++) begin
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        v   = $urandom_range(0, V - 1);
        off = $urandom_range(0, 6);
        d   = $urandom_range(0, 255);
        if (off == 1) d = $urandom_range(128, 255);
        if (off == 4 && $urandom_range(0, 7) != 0) d = d & 'hF7;
        a = BA + ST * v + off;
        if ($urandom_range(0, 9) == 0) a = $urandom_range(21, 31);
        writeReg(a, d);
      end
      if ($urandom_range(0, 3) == 0) begin
        off = $urandom_range(0, 4);
        d   = $urandom_range(0, 255);
        if (off == 4) d = d & 'hF7;
        doTick(1'b1, off, d);
      end else begin
        doTick(1'b0, 0, 0);
      end
    end
  endtask

  // Ticks every 2 clks; a tick is accepted only once the previous sweep is done.
  task automatic overrunRun(input int pulses);
    int          nextFree;
    int          dueCyc [$];
    logic [63:0] dueVal [$];
    bit          expV;
    nextFree = 0;
    for (int cyc = 0; cyc < pulses * 2 + 12; cyc++) begin
      @(negedge clk);
      expV = (dueCyc.size() > 0) && (dueCyc[0] == cyc);
      checkVal("ovrValid", 64'(bus.oValid), 64'(expV));
      if (expV) begin
        checkVal("ovrLanes", 64'(bus.oVoice), dueVal[0]);
        void'(dueCyc.pop_front());
        void'(dueVal.pop_front());
      end
      bus.clkEn = (cyc < pulses * 2) && (cyc % 2 == 0);
      if (bus.clkEn && cyc >= nextFree) begin
        modelSweep();
        dueCyc.push_back(cyc + V + 2);
        dueVal.push_back(64'(expLanes));
        nextFree = cyc + V + 1;
      end
    end
    bus.clkEn = 1'b0;
  endtask

  initial begin
    int cnt;
    nVec = 0;
    nErr = 0;
    iRstN     = 1'b0;
    bus.clkEn = 1'b0;
    bus.iWE   = 1'b0;
    bus.iAddr = '0;
    bus.iData = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkVal("rstVoice", 64'(bus.oVoice), 64'd0);
    checkVal("rstValid", 64'(bus.oValid), 64'd0);
    checkVal("rstOverrun", 64'(bus.oOverrun), 64'd0);
    iRstN = 1'b1;

    // Saw on voice 0, freq 0x1000, four widely spaced ticks
    writeReg(BA + 0, 'h00);
    writeReg(BA + 1, 'h10);
    writeReg(BA + 4, 'h20);
    for (int t = 0; t < 4; t++) begin
      doTick(1'b0, 0, 0);
      repeat (4) @(negedge clk);
    end
    checkVal("sawLane0", 64'(bus.oVoice[11:0]), 64'h AA6);

    // Pulse forced high by test bit
    writeReg(BA + 2, 'h00);
    writeReg(BA + 3, 'h08);
    writeReg(BA + 4, 'h48);
    doTick(1'b0, 0, 0);
    checkVal("pulseTestLane0", 64'(bus.oVoice[11:0]), 64'hFFF);

    // Voice 2 held in test for three ticks, then released
    writeReg(BA + ST * 2 + 1, 'h35);
    writeReg(BA + ST * 2 + 4, 'h28);
    for (int t = 0; t < 3; t++) doTick(1'b0, 0, 0);
    checkVal("testLane2", 64'(bus.oVoice[35:24]), 64'hFFF);
    writeReg(BA + ST * 2 + 4, 'h20);
    doTick(1'b0, 0, 0);

    randomPhase(600);

    checkVal("overrunClear", 64'(bus.oOverrun), 64'd0);
    overrunRun(20);
    checkVal("overrunSet", 64'(bus.oOverrun), 64'd1);

    // Reset pulsed during slot 1 aborts the sweep
    @(negedge clk);
    bus.clkEn = 1'b1;
    @(negedge clk);
    bus.clkEn = 1'b0;
    @(negedge clk);
    iRstN = 1'b0;
    #1;
    checkVal("midRstVoice", 64'(bus.oVoice), 64'd0);
    checkVal("midRstValid", 64'(bus.oValid), 64'd0);
    checkVal("midRstOverrun", 64'(bus.oOverrun), 64'd0);
    modelReset();
    @(negedge clk);
    iRstN = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.oValid) cnt++;
    end
    checkVal("noValidAfterRst", 64'(cnt), 64'd0);

    for (int k = 0; k < V; k++) begin
      writeReg(BA + ST * k + 0, $urandom_range(0, 255));
      writeReg(BA + ST * k + 1, $urandom_range(0, 255));
      writeReg(BA + ST * k + 4, 'h30);
    end
    doTick(1'b0, 0, 0);
    randomPhase(20);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
